stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
- Control and count core of the lab stopwatch; sits between the debounced button/switch inputs and the seven-segment display driver.
- Edge-detects debounced pause and reset buttons and runs a RUN/PAUSED state machine.
- Sequences a BCD MM:SS counter from external 1 Hz and 2 Hz tick pulses.
- Handles adjust mode: the selected field advances at 2 Hz and blinks.

Parameters:
- SEC_MAX, 59, terminal value of the seconds field before wrapping to 0 (BCD, at most 99)
- MIN_MAX, 59, terminal value of the minutes field before wrapping to 0 (BCD, at most 99)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- tick_1hz  input  1  single-cycle count-enable pulse, 1 Hz
- tick_2hz  input  1  single-cycle adjust/blink pulse, 2 Hz
- pause_btn  input  1  debounced pause button level (cleanbtn from debouncer)
- reset_btn  input  1  debounced reset button level
- adj_sw  input  1  1 = adjust mode
- sel_sw  input  1  adjust field select: 0 = minutes, 1 = seconds
- min_tens  output  4  BCD minutes tens
- min_ones  output  4  BCD minutes ones
- sec_tens  output  4  BCD seconds tens
- sec_ones  output  4  BCD seconds ones
- running  output  1  1 when state = RUN
- blank_min  output  1  1 = display driver blanks the minute digits
- blank_sec  output  1  1 = display driver blanks the second digits

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values:
  - state = PAUSED; all BCD digits = 0; running = 0.
  - blink_phase = 0; blank_min = blank_sec = 0.
  - Edge-detect history registers load the current pause_btn/reset_btn during rst. A button held through reset therefore produces no edge after reset.
- Edge detect: pause_ev and reset_ev are 1-cycle pulses on a 0->1 transition of the registered history. Holding a button produces exactly one event.
- State machine (2 states):
  - PAUSED --pause_ev--> RUN
  - RUN --pause_ev--> PAUSED
  - any state --reset_ev--> PAUSED, with all digits cleared to 00:00 in the same cycle.
  - reset_ev has priority over pause_ev and over any tick in the same cycle.
- Counting (adj_sw = 0, state = RUN, tick_1hz = 1):
  - seconds += 1.
  - When seconds == SEC_MAX: seconds -> 0 and minutes += 1.
  - When minutes == MIN_MAX as well: minutes -> 0, so 59:59 -> 00:00.
  - BCD ones wrap 9 -> 0 with carry into tens.
  - In PAUSED, tick_1hz is ignored.
- Adjust (adj_sw = 1):
  - tick_1hz is ignored regardless of state.
  - On tick_2hz, the selected field (sel_sw) increments by 1, wrapping at its MAX to 0. There is no carry between fields; the other field holds.
  - pause_ev still toggles the state, and running reflects it; counting resumes only after adj_sw returns to 0.
  - reset_ev clears the counter in adjust as well.
- Blink:
  - blink_phase toggles on every tick_2hz while adj_sw = 1.
  - blink_phase is forced to 0 when adj_sw = 0.
  - blank_min = adj_sw & ~sel_sw & blink_phase.
  - blank_sec = adj_sw & sel_sw & blink_phase.
- Latency: all outputs are registered. Digits, running and blank flags change on the clk edge that samples the triggering event, and are visible the following cycle.
- Switch changes: adj_sw/sel_sw changes take effect the same cycle they are sampled. Switches are not edge-detected.
- Mid-operation reset: rst asserted at any time returns all outputs to reset values on the next edge, independent of ticks or buttons.
- Digit bound: BCD digits never exceed 9; tens digits never exceed the tens of the corresponding MAX.

Test Plan:
- Start/count: after rst, pulse pause_btn, then issue 61 tick_1hz -> running = 1 and display 01:01. A further pause_btn pulse and 5 ticks -> still 01:01 with running = 0.
- Wrap: in RUN at 59:58, issue 2 tick_1hz -> 59:59, then 00:00 with no illegal BCD digit. Seconds 09 -> 10 ones/tens carry checked.
- Reset priority: in RUN at 12:34, assert reset_btn rising, pause_btn rising and tick_1hz in the same cycle -> next cycle 00:00, running = 0. reset_btn held for 100 cycles -> no further events.
- Adjust: adj_sw = 1, sel_sw = 0 at 58:10, issue 3 tick_2hz -> 01:10 (minutes wrap 59 -> 00, seconds untouched). blank_min toggles 1,0,1 on each tick; blank_sec = 0. Concurrent tick_1hz pulses are ignored.
- Adjust seconds and exit: sel_sw = 1, 2 tick_2hz from xx:59 -> xx:01 with no minute carry. Set adj_sw = 0 -> blank flags 0 next cycle and normal counting resumes if RUN.
- Held-button reset: hold pause_btn = 1 across rst deassertion -> no pause_ev and running stays 0. Release and press again -> running = 1.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control/count core: button edge detect, RUN/PAUSED FSM,
// BCD MM:SS counter driven by 1 Hz ticks, and 2 Hz adjust with field blink.
module stopwatch_ctrl #(
  parameter int SEC_MAX = 59,
  parameter int MIN_MAX = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       pause_btn,
  input  logic       reset_btn,
  input  logic       adj_sw,
  input  logic       sel_sw,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       blank_min,
  output logic       blank_sec
);

  typedef enum logic {PAUSED = 1'b0, RUN = 1'b1} state_t;

  localparam logic [7:0] SEC_MAX_BCD = {4'(SEC_MAX / 10), 4'(SEC_MAX % 10)};
  localparam logic [7:0] MIN_MAX_BCD = {4'(MIN_MAX / 10), 4'(MIN_MAX % 10)};

  // Two-digit BCD increment that wraps to 00 after reaching max_v.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
    if (v == max_v)
      return 8'h00;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  state_t     state_q, state_d;
  logic       pause_hist_q, reset_hist_q;
  logic [7:0] sec_q, sec_d;
  logic [7:0] min_q, min_d;
  logic       blink_q, blink_d;
  logic       blank_min_q, blank_min_d;
  logic       blank_sec_q, blank_sec_d;
  logic       pause_ev, reset_ev;

  always_comb begin
    pause_ev = pause_btn & ~pause_hist_q;
    reset_ev = reset_btn & ~reset_hist_q;
    state_d  = state_q;
    sec_d    = sec_q;
    min_d    = min_q;

    if (reset_ev) begin
      state_d = PAUSED;
      sec_d   = 8'h00;
      min_d   = 8'h00;
    end else begin
      if (pause_ev)
        state_d = (state_q == RUN) ? PAUSED : RUN;
      // Adjust mode owns the counter: fields step independently, no carry.
      if (adj_sw) begin
        if (tick_2hz) begin
          if (sel_sw)
            sec_d = bcd_inc(sec_q, SEC_MAX_BCD);
          else
            min_d = bcd_inc(min_q, MIN_MAX_BCD);
        end
      end else if ((state_q == RUN) && tick_1hz) begin
        sec_d = bcd_inc(sec_q, SEC_MAX_BCD);
        if (sec_q == SEC_MAX_BCD)
          min_d = bcd_inc(min_q, MIN_MAX_BCD);
      end
    end

    blink_d     = adj_sw & (blink_q ^ tick_2hz);
    blank_min_d = adj_sw & ~sel_sw & blink_d;
    blank_sec_d = adj_sw &  sel_sw & blink_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= PAUSED;
      pause_hist_q <= pause_btn;
      reset_hist_q <= reset_btn;
      sec_q        <= 8'h00;
      min_q        <= 8'h00;
      blink_q      <= 1'b0;
      blank_min_q  <= 1'b0;
      blank_sec_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pause_hist_q <= pause_btn;
      reset_hist_q <= reset_btn;
      sec_q        <= sec_d;
      min_q        <= min_d;
      blink_q      <= blink_d;
      blank_min_q  <= blank_min_d;
      blank_sec_q  <= blank_sec_d;
    end
  end

  assign min_tens  = min_q[7:4];
  assign min_ones  = min_q[3:0];
  assign sec_tens  = sec_q[7:4];
  assign sec_ones  = sec_q[3:0];
  assign running   = (state_q == RUN);
  assign blank_min = blank_min_q;
  assign blank_sec = blank_sec_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios plus random
// stimulus, compared every cycle against an integer-arithmetic reference.
module tb_stopwatch_ctrl;

  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;

  logic       clk = 1'b0;
  logic       rst, tick_1hz, tick_2hz, pause_btn, reset_btn, adj_sw, sel_sw;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       running, blank_min, blank_sec;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.SEC_MAX(SEC_MAX), .MIN_MAX(MIN_MAX)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
    .pause_btn(pause_btn), .reset_btn(reset_btn), .adj_sw(adj_sw), .sel_sw(sel_sw),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .running(running), .blank_min(blank_min), .blank_sec(blank_sec)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: plain integers for the time, booleans for the rest.
  int m_sec, m_min;
  bit m_run, m_blink, m_bmin, m_bsec, m_pprev, m_rprev;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit pev, rev;
    if (rst) begin
      m_run = 0; m_sec = 0; m_min = 0;
      m_blink = 0; m_bmin = 0; m_bsec = 0;
      m_pprev = pause_btn; m_rprev = reset_btn;
    end else begin
      pev = pause_btn && !m_pprev;
      rev = reset_btn && !m_rprev;
      m_pprev = pause_btn;
      m_rprev = reset_btn;
      if (rev) begin
        m_run = 0; m_sec = 0; m_min = 0;
      end else begin
        if (adj_sw) begin
          if (tick_2hz) begin
            if (sel_sw) m_sec = (m_sec + 1) % (SEC_MAX + 1);
            else        m_min = (m_min + 1) % (MIN_MAX + 1);
          end
        end else if (m_run && tick_1hz) begin
          m_sec = m_sec + 1;
          if (m_sec > SEC_MAX) begin
            m_sec = 0;
            m_min = (m_min + 1) % (MIN_MAX + 1);
          end
        end
        if (pev) m_run = !m_run;
      end
      if (!adj_sw) m_blink = 0;
      else if (tick_2hz) m_blink = !m_blink;
      m_bmin = adj_sw && !sel_sw && m_blink;
      m_bsec = adj_sw && sel_sw && m_blink;
    end
  endtask

  task automatic check_all();
    check("min_tens", 32'(min_tens), 32'(m_min / 10));
    check("min_ones", 32'(min_ones), 32'(m_min % 10));
    check("sec_tens", 32'(sec_tens), 32'(m_sec / 10));
    check("sec_ones", 32'(sec_ones), 32'(m_sec % 10));
    check("running", 32'(running), 32'(m_run));
    check("blank_min", 32'(blank_min), 32'(m_bmin));
    check("blank_sec", 32'(blank_sec), 32'(m_bsec));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic cyc(input bit t1, input bit t2, input bit pb, input bit rb);
    tick_1hz = t1; tick_2hz = t2; pause_btn = pb; reset_btn = rb;
    step();
    tick_1hz = 0; tick_2hz = 0;
  endtask

  task automatic press_pause();
    cyc(0, 0, 1, reset_btn);
    cyc(0, 0, 0, reset_btn);
  endtask

  function automatic logic [15:0] disp();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  initial begin
    rst = 1; tick_1hz = 0; tick_2hz = 0; pause_btn = 0; reset_btn = 0;
    adj_sw = 0; sel_sw = 0;
    step(); step();
    check("rst_disp", 32'(disp()), 32'h0000);
    check("rst_run", 32'(running), 32'd0);
    rst = 0;
    step();

    // Start and count to 01:01, then pause.
    press_pause();
    for (int i = 0; i < 61; i++) cyc(1, 0, 0, 0);
    check("start_disp", 32'(disp()), 32'h0101);
    check("start_run", 32'(running), 32'd1);
    press_pause();
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0);
    check("pause_disp", 32'(disp()), 32'h0101);
    check("pause_run", 32'(running), 32'd0);

    // Set 59:58 through adjust, then wrap.
    adj_sw = 1; sel_sw = 0;
    for (int i = 0; i < 58; i++) cyc(0, 1, 0, 0);
    sel_sw = 1;
    for (int i = 0; i < 57; i++) cyc(0, 1, 0, 0);
    adj_sw = 0;
    step();
    check("set_disp", 32'(disp()), 32'h5958);
    press_pause();
    cyc(1, 0, 0, 0);
    check("wrap_5959", 32'(disp()), 32'h5959);
    cyc(1, 0, 0, 0);
    check("wrap_0000", 32'(disp()), 32'h0000);
    for (int i = 0; i < 9; i++) cyc(1, 0, 0, 0);
    check("carry_09", 32'(disp()), 32'h0009);
    cyc(1, 0, 0, 0);
    check("carry_10", 32'(disp()), 32'h0010);

    // Reset priority at 12:34 in RUN.
    adj_sw = 1; sel_sw = 0;
    for (int i = 0; i < 12; i++) cyc(0, 1, 0, 0);
    sel_sw = 1;
    for (int i = 0; i < 24; i++) cyc(0, 1, 0, 0);
    adj_sw = 0;
    step();
    check("pri_pre", 32'(disp()), 32'h1234);
    check("pri_pre_run", 32'(running), 32'd1);
    cyc(1, 0, 1, 1);
    check("pri_disp", 32'(disp()), 32'h0000);
    check("pri_run", 32'(running), 32'd0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 1);
    for (int i = 0; i < 100; i++) cyc(1, 0, 1, 1);
    check("held_disp", 32'(disp()), 32'h0140);
    check("held_run", 32'(running), 32'd1);
    cyc(0, 0, 0, 0);

    // Adjust minutes from 58:10 with blink.
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    press_pause();
    adj_sw = 1; sel_sw = 0;
    for (int i = 0; i < 58; i++) cyc(0, 1, 0, 0);
    sel_sw = 1;
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0);
    adj_sw = 0;
    step();
    check("adj_pre", 32'(disp()), 32'h5810);
    adj_sw = 1; sel_sw = 0;
    cyc(1, 1, 0, 0);
    check("blink1_min", 32'(blank_min), 32'd1);
    check("blink1_sec", 32'(blank_sec), 32'd0);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    check("blink2_min", 32'(blank_min), 32'd0);
    cyc(1, 1, 0, 0);
    check("blink3_min", 32'(blank_min), 32'd1);
    check("adj_min_disp", 32'(disp()), 32'h0110);

    // Adjust seconds across 59 with no minute carry, then exit.
    sel_sw = 1;
    for (int i = 0; i < 49; i++) cyc(0, 1, 0, 0);
    check("adj_sec_59", 32'(disp()), 32'h0159);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    check("adj_sec_disp", 32'(disp()), 32'h0101);
    adj_sw = 0;
    step();
    check("exit_bmin", 32'(blank_min), 32'd0);
    check("exit_bsec", 32'(blank_sec), 32'd0);
    cyc(1, 0, 0, 0);
    check("exit_count", 32'(disp()), 32'h0102);

    // Pause button held through reset.
    pause_btn = 1; rst = 1;
    step(); step();
    rst = 0;
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0);
    check("hold_run", 32'(running), 32'd0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    check("hold_press_run", 32'(running), 32'd1);

    // Random stimulus against the reference model.
    for (int i = 0; i < 4000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      tick_1hz  = ($urandom_range(0, 3) == 0);
      tick_2hz  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0) pause_btn = ~pause_btn;
      if ($urandom_range(0, 59) == 0) reset_btn = ~reset_btn;
      if ($urandom_range(0, 99) == 0) adj_sw = ~adj_sw;
      if ($urandom_range(0, 49) == 0) sel_sw = ~sel_sw;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
